// File: rtl/mips_pkg.sv
// mips_pkg: the MIPS instruction kinds, 6-bit opcodes, encoder FSM states and field packing
// helpers shared by the instruction encoder and the main decoder.
// Build option: INSTR_ENCODER_LI32_EN enables the two-word LI32 pseudo-instruction and the
// HOLD2 state that goes with it.
package mips_pkg;

    typedef enum logic [3:0] {
        KindRtype = 4'd0,
        KindLw    = 4'd1,
        KindSw    = 4'd2,
        KindBeq   = 4'd3,
        KindAddi  = 4'd4,
        KindJ     = 4'd5,
        KindXori  = 4'd6,
        KindLui   = 4'd7,
        KindBgtz  = 4'd8,
        KindLi    = 4'd9,
        KindLi32  = 4'd10
    } instr_kind_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_LI    = 6'b010001;

`ifdef INSTR_ENCODER_LI32_EN
    // StHold2: first LI32 word is on the output, the second is waiting behind it.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StHold  = 2'd1,
        StHold2 = 2'd2
    } enc_state_t;
`else
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHold = 1'b1
    } enc_state_t;
`endif

    typedef struct packed {
        logic        legal;
        logic        last;
        logic [31:0] word;
    } enc_result_t;

    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] pack_j(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

    // First (often only) word of a request; legal=0 for kinds this build cannot encode.
    function automatic enc_result_t encode_first(input logic [3:0]  kind,
                                                 input logic [4:0]  rs,
                                                 input logic [4:0]  rt,
                                                 input logic [4:0]  rd,
                                                 input logic [5:0]  funct,
                                                 input logic [31:0] imm,
                                                 input logic [25:0] target);
        enc_result_t res;
        res.legal = 1'b1;
        res.last  = 1'b1;
        res.word  = '0;
        case (kind)
            KindRtype: res.word = pack_r(rs, rt, rd, funct);
            KindLw:    res.word = pack_i(OP_LW, rs, rt, imm[15:0]);
            KindSw:    res.word = pack_i(OP_SW, rs, rt, imm[15:0]);
            KindBeq:   res.word = pack_i(OP_BEQ, rs, rt, imm[15:0]);
            KindAddi:  res.word = pack_i(OP_ADDI, rs, rt, imm[15:0]);
            KindJ:     res.word = pack_j(OP_J, target);
            KindXori:  res.word = pack_i(OP_XORI, rs, rt, imm[15:0]);
            KindLui:   res.word = pack_i(OP_LUI, 5'd0, rt, imm[15:0]);
            KindBgtz:  res.word = pack_i(OP_BGTZ, rs, 5'd0, imm[15:0]);
            KindLi:    res.word = pack_i(OP_LI, 5'd0, rt, imm[15:0]);
`ifdef INSTR_ENCODER_LI32_EN
            KindLi32: begin
                res.word = pack_i(OP_LUI, 5'd0, rt, imm[31:16]);
                res.last = 1'b0;
            end
`endif
            default: begin
                res.legal = 1'b0;
                res.last  = 1'b0;
            end
        endcase
        return res;
    endfunction

    // Second LI32 word: XORI rt,rt,imm[15:0] fills the low half left zero by LUI.
    function automatic logic [31:0] encode_li32_low(input logic [4:0] rt, input logic [15:0] imm);
        return pack_i(OP_XORI, rt, rt, imm);
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// instr_encoder: turns one instruction request into one (or, for LI32, two) 32-bit MIPS words
// on a valid/ready output stream with a single output register stage.
// Build option: INSTR_ENCODER_LI32_EN enables LI32; otherwise LI32 is reported as illegal.
module instr_encoder
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_kind,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [5:0]  req_funct,
    input  logic [31:0] req_imm,
    input  logic [25:0] req_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        err_illegal,
    output logic [15:0] emitted_cnt
);

    enc_state_t  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    enc_result_t enc;
    logic        accept;
    logic        out_fire;
`ifdef INSTR_ENCODER_LI32_EN
    logic [31:0] pend_q, pend_d;
`endif

    // Handshake qualifiers; a new request may replace a word only as that word leaves.
    always_comb begin
        out_valid = (state_q != StIdle);
        req_ready = (state_q == StIdle) || ((state_q == StHold) && out_ready);
        accept    = req_valid && req_ready;
        out_fire  = out_valid && out_ready;
        enc       = encode_first(req_kind, req_rs, req_rt, req_rd, req_funct, req_imm,
                                 req_target);
    end

    // Next-state: drain the held word, then load an accepted request on top of it.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        last_d  = last_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q + {15'd0, out_fire};
`ifdef INSTR_ENCODER_LI32_EN
        pend_d  = pend_q;
        if ((state_q == StHold2) && out_ready) begin
            state_d = StHold;
            instr_d = pend_q;
            last_d  = 1'b1;
        end
`endif
        if ((state_q == StHold) && out_ready) begin
            state_d = StIdle;
        end
        if (accept) begin
            if (enc.legal) begin
                instr_d = enc.word;
                last_d  = enc.last;
                state_d = StHold;
`ifdef INSTR_ENCODER_LI32_EN
                if (!enc.last) begin
                    state_d = StHold2;
                    pend_d  = encode_li32_low(req_rt, req_imm[15:0]);
                end
`endif
            end else begin
                err_d   = 1'b1;
                state_d = StIdle;
            end
        end
    end

    // State and output registers; reset also drops any pending second LI32 word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            instr_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef INSTR_ENCODER_LI32_EN
            pend_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef INSTR_ENCODER_LI32_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign out_instr   = instr_q;
    assign out_last    = last_q;
    assign err_illegal = err_q;
    assign emitted_cnt = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed known-answer cases plus randomized requests; a monitor compares
// every output handshake against words queued by a reference encoder when requests are accepted.
`timescale 1ns/1ps
module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_kind;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [5:0]  req_funct;
    logic [31:0] req_imm;
    logic [25:0] req_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        err_illegal;
    logic [15:0] emitted_cnt;

    int checks   = 0;
    int failures = 0;
    int model_cnt = 0;
    int rdy_mode  = 0;  // 0: always ready, 1: random, 2: stalled
    bit illegal_next;
    bit err_exp = 0;
    logic [32:0] exp_q[$];  // {last, word}

    instr_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_kind    (req_kind),
        .req_rs      (req_rs),
        .req_rt      (req_rt),
        .req_rd      (req_rd),
        .req_funct   (req_funct),
        .req_imm     (req_imm),
        .req_target  (req_target),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_last    (out_last),
        .err_illegal (err_illegal),
        .emitted_cnt (emitted_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: MIPS field layouts written straight from the instruction formats.
    function automatic void model_push(input logic [3:0] k, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [5:0] fn, input logic [31:0] imm,
                                       input logic [25:0] tg);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = imm[15:0];
        hi = imm[31:16];
        case (k)
            4'd0:  exp_q.push_back({1'b1, 6'b000000, rs, rt, rd, 5'b00000, fn});
            4'd1:  exp_q.push_back({1'b1, 6'b100011, rs, rt, lo});
            4'd2:  exp_q.push_back({1'b1, 6'b101011, rs, rt, lo});
            4'd3:  exp_q.push_back({1'b1, 6'b000100, rs, rt, lo});
            4'd4:  exp_q.push_back({1'b1, 6'b001000, rs, rt, lo});
            4'd5:  exp_q.push_back({1'b1, 6'b000010, tg});
            4'd6:  exp_q.push_back({1'b1, 6'b001110, rs, rt, lo});
            4'd7:  exp_q.push_back({1'b1, 6'b001111, 5'b00000, rt, lo});
            4'd8:  exp_q.push_back({1'b1, 6'b000111, rs, 5'b00000, lo});
            4'd9:  exp_q.push_back({1'b1, 6'b010001, 5'b00000, rt, lo});
`ifdef INSTR_ENCODER_LI32_EN
            4'd10: begin
                exp_q.push_back({1'b0, 6'b001111, 5'b00000, rt, hi});
                exp_q.push_back({1'b1, 6'b001110, rt, rt, lo});
            end
`endif
            default: illegal_next = 1'b1;
        endcase
    endfunction

    // out_ready driver, changed just after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 9) < 7);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: sample on the falling edge, check against queue occupancy and contents.
    initial begin
        int qs;
        bit stalled;
        logic [32:0] held;
        logic [32:0] e;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                model_cnt = 0;
                err_exp = 1'b0;
                stalled = 1'b0;
                continue;
            end
            qs = exp_q.size();
            chk("err_illegal", {32'd0, err_illegal}, {32'd0, err_exp});
            chk("out_valid", {32'd0, out_valid}, {32'd0, (qs != 0)});
            chk("req_ready", {32'd0, req_ready}, {32'd0, (qs == 0) || (qs == 1 && out_ready)});
            chk("emitted_cnt", {17'd0, emitted_cnt}, {17'd0, model_cnt[15:0]});
            if (stalled && out_valid) chk("hold_stable", {out_last, out_instr}, held);
            stalled = out_valid && !out_ready;
            held = {out_last, out_instr};
            if (out_valid && out_ready) begin
                if (qs != 0) begin
                    e = exp_q.pop_front();
                    chk("out_word", {out_last, out_instr}, e);
                end
                model_cnt++;
            end
            err_exp = 1'b0;
            if (req_valid && req_ready) begin
                illegal_next = 1'b0;
                model_push(req_kind, req_rs, req_rt, req_rd, req_funct, req_imm, req_target);
                err_exp = illegal_next;
            end
        end
    end

    // Present a request from just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] fn, input logic [31:0] imm,
                         input logic [25:0] tg);
        int n;
        n = 0;
        req_kind = k;
        req_rs = rs;
        req_rt = rt;
        req_rd = rd;
        req_funct = fn;
        req_imm = imm;
        req_target = tg;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        req_valid = 1'b0;
        req_kind = '0;
        req_rs = '0;
        req_rt = '0;
        req_rd = '0;
        req_funct = '0;
        req_imm = '0;
        req_target = '0;
        #2;
        chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
        chk("rst_out_instr", {1'b0, out_instr}, 33'd0);
        chk("rst_out_last", {32'd0, out_last}, 33'd0);
        chk("rst_err", {32'd0, err_illegal}, 33'd0);
        chk("rst_cnt", {17'd0, emitted_cnt}, 33'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("idle_req_ready", {32'd0, req_ready}, 33'd1);
        @(posedge clk);
        #1;

        // ADDI rs=2 rt=3 imm=5
        issue(4'd4, 5'd2, 5'd3, 5'd0, 6'd0, 32'h0000_0005, 26'd0);
        chk("addi_word", {out_last, out_instr}, {1'b1, 32'h2043_0005});
        idle();
        chk("addi_cnt", {17'd0, emitted_cnt}, 33'd1);

        // Back-to-back BGTZ then J
        issue(4'd8, 5'd4, 5'd0, 5'd0, 6'd0, 32'h0000_FFFE, 26'd0);
        chk("bgtz_word", {1'b0, out_instr}, {1'b0, 32'h1C80_FFFE});
        issue(4'd5, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 26'h000_0100);
        chk("j_word", {1'b0, out_instr}, {1'b0, 32'h0800_0100});
        idle();
        idle();

        // LI32 rt=8 imm=0x12345678
        issue(4'd10, 5'd0, 5'd8, 5'd0, 6'd0, 32'h1234_5678, 26'd0);
`ifdef INSTR_ENCODER_LI32_EN
        chk("li32_hi", {out_last, out_instr}, {1'b0, 32'h3C08_1234});
        chk("li32_ready", {32'd0, req_ready}, 33'd0);
        idle();
        chk("li32_lo", {out_last, out_instr}, {1'b1, 32'h3908_5678});
`else
        chk("li32_err", {32'd0, err_illegal}, 33'd1);
        chk("li32_no_valid", {32'd0, out_valid}, 33'd0);
        idle();
        chk("li32_err_clr", {32'd0, err_illegal}, 33'd0);
`endif
        idle();
        idle();

        // J under back-pressure for three cycles
        rdy_mode = 2;
        out_ready = 1'b0;
        issue(4'd5, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 26'h000_0100);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_word", {1'b0, out_instr}, {1'b0, 32'h0800_0100});
            chk("stall_ready", {32'd0, req_ready}, 33'd0);
            @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_cnt", {17'd0, emitted_cnt}, {17'd0, model_cnt[15:0]});
        chk("stall_drained", {32'd0, out_valid}, 33'd0);

        // Undefined kind
        issue(4'hF, 5'd1, 5'd2, 5'd3, 6'd4, 32'hDEAD_BEEF, 26'd5);
        chk("illegal_err", {32'd0, err_illegal}, 33'd1);
        chk("illegal_no_valid", {32'd0, out_valid}, 33'd0);
        idle();
        chk("illegal_err_clr", {32'd0, err_illegal}, 33'd0);

        // Randomized traffic with random back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            issue(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
                  6'($urandom), 32'($urandom), 26'($urandom));
            if ($urandom_range(0, 3) == 0) idle();
        end
        req_valid = 1'b0;
        rdy_mode = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
        end
        idle();

        // Reset between the two LI32 words
        issue(4'd10, 5'd0, 5'd8, 5'd0, 6'd0, 32'h1234_5678, 26'd0);
        idle();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {32'd0, out_valid}, 33'd0);
        chk("mid_rst_cnt", {17'd0, emitted_cnt}, 33'd0);
        chk("mid_rst_instr", {1'b0, out_instr}, 33'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("post_rst_quiet", {32'd0, out_valid}, 33'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
